// File: rtl/uart_tx_serializer.sv
// UART transmit back end: one-word holding register (THR) feeding a shift register (TSR)
// that serialises start/data/parity/stop bits LSB-first, paced by an oversampled baud tick.
module uart_tx_serializer #(
   parameter int OVERSAMPLE = 16
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_baud_tick16,
   input  logic [1:0] i_word_length,
   input  logic       i_parity_en,
   input  logic       i_stop_bits,
   input  logic       i_break_ctrl,
   input  logic [8:0] i_tx_data,
   input  logic       i_tx_flag,
   output logic       o_txd,
   output logic       o_thr_empty,
   output logic       o_tsr_empty
);

   localparam logic [3:0] C_FULL_END = 4'(OVERSAMPLE - 1);
   localparam logic [3:0] C_HALF_END = 4'(OVERSAMPLE / 2 - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t     r_state;
   logic [8:0] r_thr;
   logic       r_thr_empty;
   logic [8:0] r_tsr;
   logic [3:0] r_tick_cnt;
   logic [3:0] r_bit_cnt;
   logic [1:0] r_wl;
   logic       r_pen;
   logic       r_stop;
   logic       r_par;
   logic       r_txd;
   logic       r_tsr_empty;

   state_t     w_state_n;
   logic [8:0] w_tsr_n;
   logic [3:0] w_tick_n;
   logic [3:0] w_bit_n;
   logic       w_xfer;
   logic       w_thr_empty_n;
   logic       w_line_n;
   logic       w_bit_end;
   logic       w_last_data;
   logic [3:0] w_stop_last;
   logic [3:0] w_par_idx;

   // Stop is timed in half-bit units so 1.5 stop bits needs no wider counter.
   assign w_bit_end   = i_baud_tick16 &&
                        (r_tick_cnt == ((r_state == S_STOP) ? C_HALF_END : C_FULL_END));
   assign w_last_data = (r_bit_cnt == (4'd4 + {2'b00, r_wl}));
   assign w_stop_last = !r_stop ? 4'd1 : ((r_wl == 2'b00) ? 4'd2 : 4'd3);
   assign w_par_idx   = 4'd5 + {2'b00, i_word_length};

   always_comb begin
      w_state_n = r_state;
      w_tick_n  = r_tick_cnt;
      w_bit_n   = r_bit_cnt;
      w_tsr_n   = r_tsr;
      w_xfer    = 1'b0;
      if (r_state != S_IDLE && i_baud_tick16)
         w_tick_n = w_bit_end ? 4'd0 : r_tick_cnt + 4'd1;
      case (r_state)
         S_IDLE:  w_xfer = !r_thr_empty;
         S_START: if (w_bit_end) begin
            w_state_n = S_DATA;
            w_bit_n   = 4'd0;
         end
         S_DATA: if (w_bit_end) begin
            w_tsr_n = r_tsr >> 1;
            if (w_last_data) begin
               w_bit_n   = 4'd0;
               w_state_n = r_pen ? S_PARITY : S_STOP;
            end else begin
               w_bit_n = r_bit_cnt + 4'd1;
            end
         end
         S_PARITY: if (w_bit_end) begin
            w_state_n = S_STOP;
            w_bit_n   = 4'd0;
         end
         S_STOP: if (w_bit_end) begin
            if (r_bit_cnt == w_stop_last) begin
               w_bit_n = 4'd0;
               if (!r_thr_empty) w_xfer = 1'b1;
               else              w_state_n = S_IDLE;
            end else begin
               w_bit_n = r_bit_cnt + 4'd1;
            end
         end
         default: w_state_n = S_IDLE;
      endcase
      if (w_xfer) begin
         w_state_n = S_START;
         w_tick_n  = 4'd0;
         w_bit_n   = 4'd0;
         w_tsr_n   = r_thr;
      end
      w_thr_empty_n = i_tx_flag ? 1'b0 : (w_xfer ? 1'b1 : r_thr_empty);
      // Line value is computed for the next state so txd can be a plain register.
      case (w_state_n)
         S_START:  w_line_n = 1'b0;
         S_DATA:   w_line_n = w_tsr_n[0];
         S_PARITY: w_line_n = r_par;
         default:  w_line_n = 1'b1;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_thr       <= '0;
         r_thr_empty <= 1'b1;
         r_tsr       <= '0;
         r_tick_cnt  <= '0;
         r_bit_cnt   <= '0;
         r_wl        <= '0;
         r_pen       <= 1'b0;
         r_stop      <= 1'b0;
         r_par       <= 1'b0;
         r_txd       <= 1'b1;
         r_tsr_empty <= 1'b1;
      end else begin
         r_state     <= w_state_n;
         r_tsr       <= w_tsr_n;
         r_tick_cnt  <= w_tick_n;
         r_bit_cnt   <= w_bit_n;
         r_thr_empty <= w_thr_empty_n;
         if (i_tx_flag) r_thr <= i_tx_data;
         if (w_xfer) begin
            r_wl   <= i_word_length;
            r_pen  <= i_parity_en;
            r_stop <= i_stop_bits;
            r_par  <= r_thr[w_par_idx];
         end
         r_txd       <= w_line_n & ~i_break_ctrl;
         r_tsr_empty <= (w_state_n == S_IDLE) && w_thr_empty_n;
      end
   end

   assign o_txd       = r_txd;
   assign o_thr_empty = r_thr_empty;
   assign o_tsr_empty = r_tsr_empty;

endmodule
